ptm_rom_arb: RTL and testbench
==============================

PTM_ROM_ARB -- requirements
Module: ptm_rom_arb

Interface
REQ-001 Parameter ADDR_W, default 10, ROM address width (1024-word info ROM).
REQ-002 Parameter DATA_W, default 10, ROM read data width (info word without its flag bit).
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  read request from PTM engine 0 / 1.
REQ-006 addr0 / addr1  input  ADDR_W  read address; valid while the matching req is high.
REQ-007 gnt0 / gnt1  output  1  combinational accept; a request is accepted on an edge where req_i and gnt_i are both high.
REQ-008 rvalid0 / rvalid1  output  1  one-cycle pulse; rdata_i is valid.
REQ-009 rdata0 / rdata1  output  DATA_W  registered read data for requester i.
REQ-010 rom_en  output  1  registered ROM read enable.
REQ-011 rom_addr  output  ADDR_W  registered ROM address.
REQ-012 rom_data  input  DATA_W  combinational ROM data, valid during the cycle rom_en is high.

Function
REQ-013 gnt0/gnt1 SHALL be one-hot or zero and never both high.
REQ-014 A single requesting engine SHALL be granted in that same cycle.
REQ-015 Simultaneous requests SHALL resolve round-robin: grant the requester not granted last, tracked by a 1-bit pointer rr.
REQ-016 rr SHALL update only on an accepted request, to the index of the accepted requester.
REQ-017 Pipeline stage S1, the cycle after acceptance: rom_en=1, rom_addr=accepted address, owner register = accepted index.
REQ-018 Pipeline stage S2, the cycle after S1: rvalid_owner=1, rdata_owner = rom_data sampled at the end of S1; the other requester's rvalid stays 0.
REQ-019 Latency from the accept edge to the rvalid pulse SHALL be exactly 2 cycles; throughput SHALL be one accept per cycle, sustained back-to-back.
REQ-020 rom_en SHALL be 0 in any cycle that follows a cycle with no accept; rom_addr then holds its last value.
REQ-021 rdata_i SHALL hold its last value when rvalid_i is 0.
REQ-022 Read order per requester SHALL equal accept order; there is no reordering and no drop.
REQ-023 A requester holding req high without gnt SHALL see its address unused; the held address is not latched early.
REQ-024 Address range 0..1023 SHALL pass unmodified; there is no wrap or clamp logic.

Reset
REQ-025 While rst=1: gnt0=gnt1=0, rom_en=0, rom_addr=0, rvalid0=rvalid1=0, rdata0=rdata1=0, rr=1 (requester 0 favoured first).
REQ-026 Reset asserted mid-operation SHALL discard all in-flight reads; no rvalid pulse occurs for them after reset releases.
REQ-027 On the first cycle after rst falls, arbitration SHALL resume normally.

Configuration
REQ-028 Macro PTM_ARB_STAT_EN: when defined, add outputs gcnt0 and gcnt1 (16 bits each), which count accepts per requester, saturate at 16'hFFFF, and clear on rst.
REQ-029 Without PTM_ARB_STAT_EN, the gcnt ports and counters SHALL be absent and all other behaviour is identical.

Verification
REQ-030 Single requester: req0=1 with addr0=0..1023 consecutively for 1024 cycles, rom_data=addr+3 -> gnt0 every cycle, rvalid0 every cycle from cycle 3, rdata0=addr+3 in order, rvalid1 never.
REQ-031 Contention: req0 and req1 held high, addr0=5, addr1=9 -> grants alternate 0,1,0,1 starting with 0; rom_addr alternates 5,9; each rvalid pulses every other cycle.
REQ-032 Idle gap: one accept at addr 100, then no requests -> rom_en high for 1 cycle only, one rvalid, then rom_en=0 and rdata frozen at the returned value.
REQ-033 Reset mid-flight: accept at addr 7, assert rst on the next edge -> no rvalid afterwards, all outputs 0, first post-reset contention grants requester 0.
REQ-034 Boundary address: addr1=1023, rom_data=10'h3FF -> rvalid1 with rdata1=10'h3FF exactly 2 cycles after accept.
REQ-035 With PTM_ARB_STAT_EN: 70000 accepts on requester 0 -> gcnt0=16'hFFFF and gcnt1=0; rst clears both to 0.

Source files
------------

// File: rtl/ptm_rom_arb.sv
// Two-requester round-robin arbiter in front of a single-port info ROM (optional macro PTM_ARB_STAT_EN adds per-requester accept counters).
// Latency: 2 cycles from the accept edge to the rvalid pulse, one accept per cycle sustained.
// Backpressure: gnt is the only flow control; a request without gnt is ignored and its address is not latched.
module ptm_rom_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
`ifdef PTM_ARB_STAT_EN
  ,
  output logic [15:0]       gcnt0,
  output logic [15:0]       gcnt1
`endif
);

  // rr holds the index of the requester granted last; 1 after reset so requester 0 wins first.
  logic rr;
  // owner of the read currently in the ROM stage
  logic owner;
  logic accept;

  // Grant: a lone requester wins immediately, a tie goes to the one not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = rr;
        gnt1 = ~rr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign accept = gnt0 | gnt1;

  // Round-robin pointer follows the accepted requester only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= 1'b1;
    end else if (accept) begin
      rr <= gnt1;
    end
  end

  // Stage S1: launch the ROM read for the accepted request; address holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
      owner    <= 1'b0;
    end else begin
      rom_en <= accept;
      if (accept) begin
        rom_addr <= gnt1 ? addr1 : addr0;
        owner    <= gnt1;
      end
    end
  end

  // Stage S2: capture ROM data for the owner; the other requester's data stays frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= rom_en & ~owner;
      rvalid1 <= rom_en & owner;
      if (rom_en && !owner) rdata0 <= rom_data;
      if (rom_en && owner)  rdata1 <= rom_data;
    end
  end

`ifdef PTM_ARB_STAT_EN
  // Saturating accept counters, one per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt0 && gcnt0 != 16'hFFFF) gcnt0 <= gcnt0 + 16'd1;
      if (gnt1 && gcnt1 != 16'hFFFF) gcnt1 <= gcnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ptm_rom_arb.sv
// Scoreboard bench for ptm_rom_arb: the driver predicts grants and pushes expected reads,
// a negedge monitor pops and compares data and arrival cycle on every rvalid pulse.
// ROM model returns rom_addr + rom_off.
module tb_ptm_rom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [9:0]  addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, rom_en;
  logic [9:0]  rdata0, rdata1, rom_addr, rom_data;
  logic [9:0]  rom_off = 10'd3;
`ifdef PTM_ARB_STAT_EN
  logic [15:0] gcnt0, gcnt1;
`endif

  typedef struct {
    logic [9:0] data;
    int         due;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [9:0] last_addr = '0;
  logic [9:0] last0 = '0, last1 = '0;

  ptm_rom_arb #(.ADDR_W(10), .DATA_W(10)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
`ifdef PTM_ARB_STAT_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
  );

  assign rom_data = rom_addr + rom_off;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: pulse with no outstanding read at cycle %0d", nm, cyc);
  endtask

  // Monitor: pops the scoreboard on each rvalid, otherwise checks data is held.
  always @(negedge clk) begin
    exp_t e;
    check("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
    if (rst) begin
      last0 = '0;
      last1 = '0;
      check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      check("rst_rdata", {12'd0, rdata1, rdata0}, 32'd0);
    end else begin
      if (rvalid0) begin
        if (q0.size() == 0) unexpected("rvalid0");
        else begin
          e = q0.pop_front();
          check("rdata0", rdata0, e.data);
          check("lat0", cyc, e.due);
        end
        last0 = rdata0;
      end else check("rdata0_hold", rdata0, last0);
      if (rvalid1) begin
        if (q1.size() == 0) unexpected("rvalid1");
        else begin
          e = q1.pop_front();
          check("rdata1", rdata1, e.data);
          check("lat1", cyc, e.due);
        end
        last1 = rdata1;
      end else check("rdata1_hold", rdata1, last1);
    end
  end

  // One driver cycle, entered at negedge+2: apply request, check grant, predict the read.
  task automatic step(input logic r0, input logic [9:0] a0, input logic r1, input logic [9:0] a1,
                      input logic e0, input logic e1);
    exp_t e;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
    check("gnt0", gnt0, e0);
    check("gnt1", gnt1, e1);
    if (e0) begin e.data = a0 + rom_off; e.due = cyc + 2; q0.push_back(e); end
    if (e1) begin e.data = a1 + rom_off; e.due = cyc + 2; q1.push_back(e); end
    @(negedge clk); #2;
    check("rom_en", rom_en, e0 | e1);
    if (e0) last_addr = a0;
    else if (e1) last_addr = a1;
    check("rom_addr", rom_addr, last_addr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  // Reset with both requests held: grants must stay low and all state clears.
  task automatic do_reset(input int n);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    last_addr = '0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 10'd11; addr1 = 10'd22;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #2;
      check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      check("rst_rom_en", rom_en, 1'b0);
      check("rst_rom_addr", rom_addr, 10'd0);
    end
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    @(negedge clk); #2;
    do_reset(3);

    // single requester sweeping the full address range
    for (int a = 0; a < 1024; a++) step(1'b1, 10'(a), 1'b0, 10'd0, 1'b1, 1'b0);
    idle(3);

    // contention from reset: 0 first, then alternate
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b1, 10'd5, 1'b1, 10'd9, (i % 2) == 0, (i % 2) == 1);
    idle(3);

    // idle gap after a single accept
    step(1'b1, 10'd100, 1'b0, 10'd0, 1'b1, 1'b0);
    idle(4);

    // reset during an in-flight read
    step(1'b1, 10'd7, 1'b0, 10'd0, 1'b1, 1'b0);
    do_reset(2);
    idle(3);
    step(1'b1, 10'd40, 1'b1, 10'd50, 1'b1, 1'b0);
    step(1'b1, 10'd41, 1'b1, 10'd51, 1'b0, 1'b1);
    idle(3);

    // top address with identity ROM
    rom_off = 10'd0;
    step(1'b0, 10'd0, 1'b1, 10'd1023, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 10'd1023, 1'b0, 10'd0, 1'b1, 1'b0);
    idle(3);

`ifdef PTM_ARB_STAT_EN
    do_reset(1);
    for (int i = 0; i < 70000; i++) step(1'b1, 10'(i), 1'b0, 10'd0, 1'b1, 1'b0);
    idle(3);
    check("gcnt0_sat", gcnt0, 16'hFFFF);
    check("gcnt1_zero", gcnt1, 16'h0000);
    do_reset(1);
    check("gcnt0_rst", gcnt0, 16'h0000);
    check("gcnt1_rst", gcnt1, 16'h0000);
`endif

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
